// File: rtl/ricpu_pkg.sv
// Shared definitions for the RICPU data-memory responder.
package ricpu_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 6;
   localparam int WAIT_CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } dmem_state_t;

   // Counter start value: WAIT runs from wait_cycles-1 down to 0.
   function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_cycles);
      return (wait_cycles > 0) ? WAIT_CNT_W'(wait_cycles - 1) : '0;
   endfunction

endpackage

// File: rtl/ricpu_dmem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, no reset.
module ricpu_dmem_array
   import ricpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] w_data,
   output logic [DATA_W-1:0] r_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= w_data;
   end

   assign r_data = mem[idx];

endmodule

// File: rtl/ricpu_dmem_responder.sv
// Handshaked single-word load/store responder with programmable wait states.
//
//   state  | meaning
//   S_IDLE | waiting for mem_req; also the cycle that shows mem_ack
//   S_WAIT | counting wait states down to 0
//   S_RESP | access resolved; store committed and ack/data registered at its end
module ricpu_dmem_responder
   import ricpu_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_w_data,
   output logic              mem_busy,
   output logic              mem_ack,
   output logic [DATA_W-1:0] mem_r_data,
   output logic              mem_err
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

   dmem_state_t             state, state_nxt;
   logic [WAIT_CNT_W-1:0]   cnt, cnt_nxt;
   logic                    lat_we;
   logic [31:0]             lat_addr;
   logic [DATA_W-1:0]       lat_w_data;
   logic                    addr_err;
   logic [ADDR_W-1:0]       idx;
   logic                    arr_we;
   logic [DATA_W-1:0]       arr_r_data;

   assign addr_err = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (ADDR_W + 2)) != 32'd0);
   assign idx      = lat_addr[ADDR_W+1:2];
   // Reset forces S_IDLE asynchronously, so a store caught mid-flight never commits.
   assign arr_we   = (state == S_RESP) && lat_we && !addr_err;
   assign mem_busy = (state != S_IDLE);

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (mem_req) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt == '0) state_nxt = S_RESP;
            else           cnt_nxt   = cnt - 1'b1;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request latch; the requester may drop its inputs after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_w_data <= '0;
      end else if ((state == S_IDLE) && mem_req) begin
         lat_we     <= mem_we;
         lat_addr   <= mem_addr;
         lat_w_data <= mem_w_data;
      end
   end

   // Registered response: one-cycle ack, data and error zero outside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ack    <= 1'b0;
         mem_err    <= 1'b0;
         mem_r_data <= '0;
      end else if (state == S_RESP) begin
         mem_ack    <= 1'b1;
         mem_err    <= addr_err;
         mem_r_data <= (!addr_err && !lat_we) ? arr_r_data : '0;
      end else begin
         mem_ack    <= 1'b0;
         mem_err    <= 1'b0;
         mem_r_data <= '0;
      end
   end

   ricpu_dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk    (clk),
      .we     (arr_we),
      .idx    (idx),
      .w_data (lat_w_data),
      .r_data (arr_r_data)
   );

endmodule

// File: tb/tb_ricpu_dmem_responder.sv
// Scoreboard bench: unit a uses 2 wait states, unit b uses 0.
module tb_ricpu_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic        req_a = 1'b0, we_a = 1'b0;
   logic [31:0] addr_a = '0, wd_a = '0;
   logic        busy_a, ack_a, err_a;
   logic [31:0] rd_a;

   logic        req_b = 1'b0, we_b = 1'b0;
   logic [31:0] addr_b = '0, wd_b = '0;
   logic        busy_b, ack_b, err_b;
   logic [31:0] rd_b;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          acc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ricpu_dmem_responder #(.DATA_W(32), .ADDR_W(6), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .rst(rst), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
      .mem_w_data(wd_a), .mem_busy(busy_a), .mem_ack(ack_a), .mem_r_data(rd_a), .mem_err(err_a)
   );

   ricpu_dmem_responder #(.DATA_W(32), .ADDR_W(6), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_w_data(wd_b), .mem_busy(busy_b), .mem_ack(ack_b), .mem_r_data(rd_b), .mem_err(err_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp_v);
      end
   endtask

   // Monitor for unit a.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ack_a) begin
            if (q_a.size() == 0) begin
               checks++; failures++;
               $display("FAIL a_unexpected_ack actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = q_a.pop_front();
               chk("a_err", {31'd0, err_a}, {31'd0, e.err});
               chk("a_r_data", rd_a, e.data);
               chk("a_latency", cyc - e.acc, 32'd3);
            end
         end else begin
            chk("a_r_data_idle", rd_a, 32'd0);
         end
      end
   end

   // Monitor for unit b.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ack_b) begin
            if (q_b.size() == 0) begin
               checks++; failures++;
               $display("FAIL b_unexpected_ack actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = q_b.pop_front();
               chk("b_err", {31'd0, err_b}, {31'd0, e.err});
               chk("b_r_data", rd_b, e.data);
               chk("b_latency", cyc - e.acc, 32'd1);
            end
         end else begin
            chk("b_r_data_idle", rd_b, 32'd0);
         end
      end
   end

   task automatic wait_idle(input bit b);
      int n = 0;
      @(negedge clk);
      while ((b ? busy_b : busy_a) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; failures++;
         $display("FAIL idle_timeout actual=busy required=idle unit=%0d", b);
      end
   endtask

   // Issue one request; returns 1ns after the accepting edge.
   task automatic issue(input bit b, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic xerr, input logic [31:0] xdata,
                        input bit expect_ack);
      exp_t e;
      wait_idle(b);
      e.err = xerr; e.data = xdata; e.acc = cyc + 1;
      if (b) begin
         req_b = 1'b1; we_b = we; addr_b = addr; wd_b = wd;
         if (expect_ack) q_b.push_back(e);
      end else begin
         req_a = 1'b1; we_a = we; addr_a = addr; wd_a = wd;
         if (expect_ack) q_a.push_back(e);
      end
      @(posedge clk);
      #1;
      req_a = 1'b0; req_b = 1'b0;
      we_a = 1'b0; we_b = 1'b0;
      addr_a = 32'hFFFF_FFFF; addr_b = 32'hFFFF_FFFF;
      wd_a = 32'h0BAD_0BAD; wd_b = 32'h0BAD_0BAD;
   endtask

   task automatic drain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (q_a.size() != 0 || q_b.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q_a.size(), q_b.size());
         q_a.delete(); q_b.delete();
      end
   endtask

   initial begin
      // Reset with mem_req toggling.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_a = ~req_a; req_b = ~req_b; addr_a = 32'h10; addr_b = 32'h10;
         #1;
         chk("rst_busy", {31'd0, busy_a}, 32'd0);
         chk("rst_ack", {31'd0, ack_a}, 32'd0);
         chk("rst_r_data", rd_a, 32'd0);
         chk("rst_err", {31'd0, err_a}, 32'd0);
      end
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_no_ack", {31'd0, ack_a}, 32'd0);
      end

      // Store then load.
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
      issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

      // Misaligned.
      issue(0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1);
      issue(0, 1'b1, 32'h12, 32'h12345678, 1'b1, 32'h0, 1'b1);
      issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

      // Out of range and last legal word.
      issue(0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1);
      issue(0, 1'b1, 32'h8000_0010, 32'h55555555, 1'b1, 32'h0, 1'b1);
      issue(0, 1'b1, 32'hFC, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
      issue(0, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
      issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
      drain();

      // Back-to-back with mem_req held high: one accept every 4 cycles.
      for (int k = 0; k < 16; k++)
         issue(0, 1'b1, k * 4, 32'h1000 + k, 1'b0, 32'h0, 1'b1);
      wait_idle(0);
      for (int i = 0; i < 16; i++) begin
         exp_t e;
         req_a = 1'b1; we_a = 1'b0; addr_a = i * 4;
         if (i % 4 == 0) begin
            e.err = 1'b0; e.data = 32'h1000 + i; e.acc = cyc + 1;
            q_a.push_back(e);
         end
         @(negedge clk);
      end
      req_a = 1'b0;
      drain();

      // Reset during WAIT drops the store and the ack.
      issue(0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy_a}, 32'd0);
      chk("midrst_ack", {31'd0, ack_a}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      issue(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1008, 1'b1);
      drain();

      // Zero-wait unit: latency 1, reset during RESP drops the store.
      issue(1, 1'b1, 32'h20, 32'h11112222, 1'b0, 32'h0, 1'b1);
      issue(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222, 1'b1);
      issue(1, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0, 1'b1);
      drain();
      issue(1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      #1;
      chk("b_midrst_busy", {31'd0, busy_b}, 32'd0);
      @(posedge clk);
      #1;
      chk("b_midrst_ack", {31'd0, ack_b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      issue(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
